// File: rtl/riscv_hpm_counters.sv
// Machine counter/timer CSR block: mcycle, minstret, programmable mhpmcounters,
// their event selectors, mcountinhibit and the read-only user shadows.
module riscv_hpm_counters #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_HPM       = 4,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_we,
  input  logic [1:0]            csr_op,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_hit,
  output logic                  csr_illegal,
  input  logic                  instr_ret_i,
  input  logic [NUM_EVENTS-1:0] hpm_event_i
);

  localparam int CW = COUNTER_WIDTH;
  localparam int EW = $clog2(NUM_EVENTS + 1);
  localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] INH_MASK = 32'h5 | HPM_BITS[31:0];

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [CW-1:0] mcycle_q, mcycle_d;
  logic [CW-1:0] minstret_q, minstret_d;
  logic [CW-1:0] hpm_q [NH];
  logic [CW-1:0] hpm_d [NH];
  logic [EW-1:0] event_q [NH];
  logic [EW-1:0] event_d [NH];
  logic [31:0]   inhibit_q, inhibit_d;

  // Address decode: the low five address bits index the counter (0=cycle, 1=time, 2=instret, 3+k=hpm k).
  logic [4:0] idx;
  logic       sel_cnt_lo, sel_cnt_hi, sel_shd_lo, sel_shd_hi, sel_inh, sel_evt;

  assign idx        = csr_addr[4:0];
  assign sel_cnt_lo = (csr_addr[11:5] == 7'h58) && (idx != 5'd1);
  assign sel_cnt_hi = (csr_addr[11:5] == 7'h5C) && (idx != 5'd1);
  assign sel_shd_lo = (csr_addr[11:5] == 7'h60);
  assign sel_shd_hi = (csr_addr[11:5] == 7'h64);
  assign sel_inh    = (csr_addr == 12'h320);
  assign sel_evt    = (csr_addr[11:5] == 7'h19) && (idx >= 5'd3);

  assign csr_hit     = sel_cnt_lo | sel_cnt_hi | sel_shd_lo | sel_shd_hi | sel_inh | sel_evt;
  assign csr_illegal = csr_we & csr_hit & (csr_addr[11:8] == 4'hC);

  logic [63:0] cnt_sel;
  logic [31:0] evt_sel;

  always_comb begin
    cnt_sel = '0;
    evt_sel = '0;
    if (idx == 5'd0) cnt_sel = 64'(mcycle_q);
    if (idx == 5'd2) cnt_sel = 64'(minstret_q);
    for (int k = 0; k < NUM_HPM; k++) begin
      if (idx == 5'(k + 3)) begin
        cnt_sel = 64'(hpm_q[k]);
        evt_sel = 32'(event_q[k]);
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    if (sel_cnt_lo | sel_shd_lo)      csr_rdata = cnt_sel[31:0];
    else if (sel_cnt_hi | sel_shd_hi) csr_rdata = cnt_sel[63:32];
    else if (sel_inh)                 csr_rdata = inhibit_q;
    else if (sel_evt)                 csr_rdata = evt_sel;
  end

  logic        wr_en;
  logic [31:0] wval;

  assign wr_en = csr_we & csr_hit & ~csr_illegal & (csr_op != OP_READ);

  always_comb begin
    case (csr_op)
      OP_READ, OP_WRITE: wval = csr_wdata;
      OP_SET:            wval = csr_rdata | csr_wdata;
      OP_CLEAR:          wval = csr_rdata & ~csr_wdata;
    endcase
  end

  // A written half wins over the increment for that cycle; the other half is kept.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur, input logic wr_lo,
                                             input logic wr_hi, input logic [31:0] wv,
                                             input logic inc);
    logic [63:0] t;
    t = 64'(cur);
    if (wr_lo)      t[31:0]  = wv;
    else if (wr_hi) t[63:32] = wv;
    else            t = 64'(cur + {{(CW-1){1'b0}}, inc});
    return t[CW-1:0];
  endfunction

  function automatic logic event_fires(input logic [EW-1:0] sel, input logic [NUM_EVENTS-1:0] ev);
    logic fire;
    fire = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (32'(sel) == 32'(e + 1)) fire = ev[e];
    end
    return fire;
  endfunction

  always_comb begin
    mcycle_d   = cnt_next(mcycle_q, wr_en & sel_cnt_lo & (idx == 5'd0),
                          wr_en & sel_cnt_hi & (idx == 5'd0), wval, ~inhibit_q[0]);
    minstret_d = cnt_next(minstret_q, wr_en & sel_cnt_lo & (idx == 5'd2),
                          wr_en & sel_cnt_hi & (idx == 5'd2), wval, instr_ret_i & ~inhibit_q[2]);
    inhibit_d  = inhibit_q;
    if (wr_en & sel_inh) inhibit_d = wval & INH_MASK;
    for (int k = 0; k < NH; k++) begin
      hpm_d[k]   = hpm_q[k];
      event_d[k] = event_q[k];
      if (k < NUM_HPM) begin
        hpm_d[k] = cnt_next(hpm_q[k], wr_en & sel_cnt_lo & (idx == 5'(k + 3)),
                            wr_en & sel_cnt_hi & (idx == 5'(k + 3)), wval,
                            ~inhibit_q[k + 3] & event_fires(event_q[k], hpm_event_i));
        if (wr_en & sel_evt & (idx == 5'(k + 3))) event_d[k] = wval[EW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inhibit_q  <= '0;
      for (int k = 0; k < NH; k++) begin
        hpm_q[k]   <= '0;
        event_q[k] <= '0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inhibit_q  <= inhibit_d;
      for (int k = 0; k < NH; k++) begin
        hpm_q[k]   <= hpm_d[k];
        event_q[k] <= event_d[k];
      end
    end
  end

endmodule

// File: tb/tb_riscv_hpm_counters.sv
// Bench for riscv_hpm_counters: decode table, directed corner sequences and
// randomized traffic compared against an index-based counter model.
module tb_riscv_hpm_counters;

  localparam int CW   = 64;
  localparam int NHPM = 4;
  localparam int NEV  = 8;
  localparam int EW   = $clog2(NEV + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [11:0]    csr_addr = '0;
  logic           csr_we = 1'b0;
  logic [1:0]     csr_op = '0;
  logic [31:0]    csr_wdata = '0;
  logic [31:0]    csr_rdata;
  logic           csr_hit;
  logic           csr_illegal;
  logic           instr_ret_i = 1'b0;
  logic [NEV-1:0] hpm_event_i = '0;

  int checks = 0;
  int failures = 0;

  riscv_hpm_counters #(.COUNTER_WIDTH(CW), .NUM_HPM(NHPM), .NUM_EVENTS(NEV)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_we(csr_we), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
    .csr_illegal(csr_illegal), .instr_ret_i(instr_ret_i), .hpm_event_i(hpm_event_i)
  );

  always #5 clk = ~clk;

  // Model state indexed by counter number (0 cycle, 2 instret, 3+k hpm k).
  logic [63:0] m_cnt [32];
  logic [31:0] m_evt [32];
  logic [31:0] m_inh;

  function automatic bit m_impl(int n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NHPM);
  endfunction

  function automatic logic [31:0] m_inh_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int k = 0; k < NHPM; k++) m[3 + k] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 32; n++) begin
      m_cnt[n] = '0;
      m_evt[n] = '0;
    end
    m_inh = '0;
  endtask

  task automatic m_read(input logic [11:0] a, output bit hit, output logic [31:0] d);
    int n;
    hit = 0;
    d = '0;
    n = int'(a[4:0]);
    if ((a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) || (a >= 12'hC00 && a <= 12'hC1F)) begin
      hit = 1;
      if (m_impl(n)) d = m_cnt[n][31:0];
    end else if ((a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) || (a >= 12'hC80 && a <= 12'hC9F)) begin
      hit = 1;
      if (m_impl(n)) d = m_cnt[n][63:32];
    end else if (a == 12'h320) begin
      hit = 1;
      d = m_inh;
    end else if (a >= 12'h323 && a <= 12'h33F) begin
      hit = 1;
      n = int'(a) - 'h323;
      if (n < NHPM) d = m_evt[n];
    end
  endtask

  function automatic bit m_is_shadow(logic [11:0] a);
    return a >= 12'hC00 && a <= 12'hC9F;
  endfunction

  task automatic model_step();
    bit          hit;
    bit          fire [32];
    bit          wrote [32];
    logic [31:0] rd, w;
    logic [NEV-1:0] evv;
    int          n, s;
    m_read(csr_addr, hit, rd);
    evv = hpm_event_i;
    for (int i = 0; i < 32; i++) begin
      fire[i] = 0;
      wrote[i] = 0;
    end
    fire[0] = !m_inh[0];
    fire[2] = instr_ret_i && !m_inh[2];
    for (int k = 0; k < NHPM; k++) begin
      s = int'(m_evt[k]);
      if (!m_inh[3 + k] && s >= 1 && s <= NEV) fire[3 + k] = ((evv >> (s - 1)) & 1) != 0;
    end
    if (csr_we && hit && !m_is_shadow(csr_addr) && csr_op != 2'd0) begin
      if (csr_op == 2'd1)      w = csr_wdata;
      else if (csr_op == 2'd2) w = rd | csr_wdata;
      else                     w = rd & ~csr_wdata;
      n = int'(csr_addr[4:0]);
      if (csr_addr >= 12'hB00 && csr_addr <= 12'hB1F && m_impl(n)) begin
        m_cnt[n][31:0] = w;
        wrote[n] = 1;
      end else if (csr_addr >= 12'hB80 && csr_addr <= 12'hB9F && m_impl(n)) begin
        m_cnt[n][63:32] = w;
        wrote[n] = 1;
      end else if (csr_addr == 12'h320) begin
        m_inh = w & m_inh_mask();
      end else if (csr_addr >= 12'h323 && csr_addr <= 12'h33F) begin
        n = int'(csr_addr) - 'h323;
        if (n < NHPM) m_evt[n] = w % (32'd1 << EW);
      end
    end
    for (int i = 0; i < 32; i++) begin
      if (m_impl(i) && !wrote[i] && fire[i]) m_cnt[i] = m_cnt[i] + 64'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    bit          h;
    logic [31:0] d;
    m_read(csr_addr, h, d);
    check32({name, " rdata"}, csr_rdata, d);
    check32({name, " hit"}, 32'(csr_hit), 32'(h));
    check32({name, " illegal"}, 32'(csr_illegal), 32'(csr_we && h && m_is_shadow(csr_addr)));
  endtask

  task automatic drive(input logic [11:0] a, input logic we, input logic [1:0] op, input logic [31:0] wd);
    csr_addr = a;
    csr_we = we;
    csr_op = op;
    csr_wdata = wd;
  endtask

  task automatic read_exp(input logic [11:0] a, input logic [31:0] exp, input string name);
    drive(a, 1'b0, 2'd0, 32'h0);
    #1;
    check32(name, csr_rdata, exp);
    check_model(name);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic        hit;
    logic        ill;
  } vec_t;

  vec_t vecs [18];

  logic [11:0] rand_addrs [22];
  logic [31:0] frozen_mc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{12'hB00, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{12'hB01, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{12'hB1F, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{12'hB20, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{12'hB81, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{12'hB9F, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{12'hC01, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{12'hC1F, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{12'hC20, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{12'hC00, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{12'hC85, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{12'hCA0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{12'h320, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{12'h321, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{12'h322, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{12'h33F, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{12'h340, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{12'h300, 1'b1, 1'b0, 1'b0};

    rand_addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06, 12'hB86,
                   12'hB07, 12'hC00, 12'hC80, 12'hC01, 12'hC03, 12'hC86, 12'h320, 12'h323,
                   12'h324, 12'h326, 12'h327, 12'hB01, 12'h321, 12'h123};

    model_reset();

    // Decode table while held in reset: every readable value is zero.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].addr, vecs[i].we, 2'd1, 32'hFFFF_FFFF);
      #1;
      check32($sformatf("table[%0d] hit", i), 32'(csr_hit), 32'(vecs[i].hit));
      check32($sformatf("table[%0d] illegal", i), 32'(csr_illegal), 32'(vecs[i].ill));
      check32($sformatf("table[%0d] rdata", i), csr_rdata, 32'h0);
    end
    drive(12'h000, 1'b0, 2'd0, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ten cycles, four retirements.
    for (int i = 0; i < 10; i++) begin
      instr_ret_i = (i < 4);
      tick();
    end
    instr_ret_i = 1'b0;
    read_exp(12'hB00, 32'd10, "mcycle after 10");
    read_exp(12'hB02, 32'd4, "minstret after 10");
    tick();
    read_exp(12'hC02, 32'd4, "instret shadow");
    read_exp(12'hC01, 32'd0, "time shadow");
    tick();

    // Carry from lo into hi, then full-width wrap.
    drive(12'hB00, 1'b1, 2'd1, 32'hFFFF_FFFF); tick();
    drive(12'hB80, 1'b1, 2'd1, 32'h0);         tick();
    drive(12'h000, 1'b0, 2'd0, 32'h0);         tick();
    read_exp(12'hB80, 32'd1, "carry hi");
    read_exp(12'hB00, 32'd0, "carry lo");
    tick();
    drive(12'hB00, 1'b1, 2'd1, 32'hFFFF_FFFF); tick();
    drive(12'hB80, 1'b1, 2'd1, 32'hFFFF_FFFF); tick();
    drive(12'h000, 1'b0, 2'd0, 32'h0);         tick();
    read_exp(12'hB00, 32'd0, "wrap lo");
    read_exp(12'hB80, 32'd0, "wrap hi");
    tick();

    // Event select 3 counts only hpm_event_i[2]; out-of-range select counts nothing.
    drive(12'h323, 1'b1, 2'd1, 32'd3); tick();
    drive(12'h000, 1'b0, 2'd0, 32'h0);
    hpm_event_i = 8'h04;
    repeat (5) tick();
    hpm_event_i = 8'h01;
    repeat (7) tick();
    hpm_event_i = 8'h00;
    read_exp(12'hB03, 32'd5, "hpm3 event sel 3");
    tick();
    drive(12'h323, 1'b1, 2'd1, 32'(NEV + 1)); tick();
    drive(12'h000, 1'b0, 2'd0, 32'h0);
    hpm_event_i = '1;
    repeat (5) tick();
    hpm_event_i = '0;
    read_exp(12'hB03, 32'd5, "hpm3 sel out of range");
    read_exp(12'h323, 32'(NEV + 1), "mhpmevent3 readback");
    tick();

    // Inhibit cycle and instret; hpm keeps counting.
    drive(12'h323, 1'b1, 2'd1, 32'd1); tick();
    drive(12'h320, 1'b1, 2'd2, 32'h5); tick();
    frozen_mc = m_cnt[0][31:0];
    drive(12'h000, 1'b0, 2'd0, 32'h0);
    instr_ret_i = 1'b1;
    hpm_event_i = 8'h01;
    repeat (4) tick();
    instr_ret_i = 1'b0;
    hpm_event_i = 8'h00;
    read_exp(12'h320, 32'h5, "mcountinhibit set");
    read_exp(12'hB00, frozen_mc, "mcycle frozen");
    read_exp(12'hB02, 32'd4, "minstret frozen");
    tick();
    read_exp(12'hB03, 32'd9, "hpm3 while inhibited");
    drive(12'h320, 1'b1, 2'd3, 32'h1); tick();
    read_exp(12'hB00, frozen_mc, "mcycle clear cycle");
    read_exp(12'h320, 32'h4, "mcountinhibit cleared");
    tick();
    read_exp(12'hB00, frozen_mc + 32'd1, "mcycle resumed");
    tick();

    // Write to a read-only shadow.
    drive(12'hC00, 1'b1, 2'd1, 32'h1234);
    #1;
    check32("shadow write illegal", 32'(csr_illegal), 32'd1);
    check_model("shadow write");
    tick();
    drive(12'hC00, 1'b0, 2'd1, 32'h1234);
    #1;
    check32("shadow read illegal", 32'(csr_illegal), 32'd0);
    check32("shadow read hit", 32'(csr_hit), 32'd1);
    check_model("shadow read");
    tick();
    read_exp(12'hB00, m_cnt[0][31:0], "mcycle after illegal");
    tick();

    // Unimplemented hpm counter.
    drive(12'hB03 + 12'(NHPM), 1'b1, 2'd1, 32'hDEAD_BEEF);
    #1;
    check32("unimpl write illegal", 32'(csr_illegal), 32'd0);
    check32("unimpl write hit", 32'(csr_hit), 32'd1);
    tick();
    read_exp(12'hB03 + 12'(NHPM), 32'd0, "unimpl readback");
    tick();

    // Asynchronous reset mid-count.
    instr_ret_i = 1'b1;
    hpm_event_i = 8'h01;
    repeat (3) tick();
    drive(12'hB00, 1'b0, 2'd0, 32'h0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check32("async reset mcycle", csr_rdata, 32'd0);
    csr_addr = 12'hB02;
    #1;
    check32("async reset minstret", csr_rdata, 32'd0);
    csr_addr = 12'hB03;
    #1;
    check32("async reset hpm3", csr_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    instr_ret_i = 1'b0;
    hpm_event_i = 8'h00;
    read_exp(12'hB00, 32'd5, "mcycle after reset release");
    read_exp(12'hB02, 32'd5, "minstret after reset release");
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      a = rand_addrs[$urandom_range(0, 21)];
      drive(a, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
            (a >= 12'h323 && a <= 12'h33F) ? 32'($urandom_range(0, 10)) : $urandom);
      instr_ret_i = 1'($urandom_range(0, 1));
      hpm_event_i = NEV'($urandom);
      #1;
      check_model($sformatf("random[%0d]", i));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_hpm_counters.md
Name: riscv_hpm_counters

Overview:
- Machine counter/timer CSR block for the core: mcycle, minstret, NUM_HPM programmable mhpmcounterN, mhpmeventN and mcountinhibit, with read-only user shadows (cycle/instret/hpmcounterN and their high halves).
- Generalised successor to the fixed counter CSR address set: counter width, number of HPM counters and number of event inputs are parameters.
- Sits beside the CSR file and is selected by csr_addr; the CSR file muxes csr_rdata in when csr_hit=1.

Parameters:
- COUNTER_WIDTH, 64, implemented counter bits (33..64); bits above read 0.
- NUM_HPM, 4, implemented mhpmcounter3..(3+NUM_HPM-1) (0..29).
- NUM_EVENTS, 8, width of hpm_event_i (1..31).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- csr_addr  in  12  CSR address.
- csr_we  in  1  CSR write strobe (decoder already suppresses writes for rs1=x0 set/clear).
- csr_op  in  2  CSR_OP_READ/WRITE/SET/CLEAR encoding (00/01/10/11).
- csr_wdata  in  32  rs1/uimm operand.
- csr_rdata  out  32  combinational read data (old value).
- csr_hit  out  1  csr_addr belongs to this block.
- csr_illegal  out  1  write to read-only shadow address.
- instr_ret_i  in  1  one instruction retired this cycle.
- hpm_event_i  in  NUM_EVENTS  per-cycle event pulses.

Behaviour:
- Reset (async, rst_n=0): all counters 0, mhpmevent* 0, mcountinhibit 0. csr_rdata/csr_hit/csr_illegal are combinational from inputs, so they are 0 whenever no decoded address is presented.
- Address map:
  - 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi.
  - 0xB03+k / 0xB83+k mhpmcounter lo/hi; 0x323+k mhpmevent; 0x320 mcountinhibit.
  - 0xC00-0xC1F / 0xC80-0xC9F read-only shadows of the same counters (0xC01/0xC81 time: read 0).
  - k=0..28. Unimplemented k (>=NUM_HPM) is hit, reads 0, writes ignored (WARL).
- csr_hit=1 for any address above; else csr_rdata=0, csr_illegal=0.
- csr_illegal = csr_we & csr_hit & csr_addr[11:8]==0xC. Illegal writes change no state.
- Write value is computed from the current read value and csr_wdata:
  - WRITE: wdata.
  - SET: rd|wdata.
  - CLEAR: rd&~wdata.
  - READ with csr_we: no update.
  - Result is registered; visible on reads the next cycle.
- Lo write replaces bits[31:0] and keeps the hi half. Hi write replaces bits[COUNTER_WIDTH-1:32]; wdata bits beyond the width are dropped.
- Increment rules, evaluated every cycle:
  - mcycle +1 unless mcountinhibit[0].
  - minstret +instr_ret_i unless mcountinhibit[2].
  - HPM k: +1 if !mcountinhibit[3+k] & sel!=0 & sel<=NUM_EVENTS & hpm_event_i[sel-1], where sel=mhpmevent_k.
- CSR write to a counter half in cycle T takes priority: the counter loads the written half (other half unchanged) and does not increment in T. Writes to other CSRs do not block increments.
- Carry: lo increment carries into hi. Counter at all-ones (COUNTER_WIDTH bits) wraps to 0.
- mhpmevent stores $clog2(NUM_EVENTS+1) low bits, zero-extended on read.
- mcountinhibit: bit0, bit2 and bits 3..3+NUM_HPM-1 writable; bit1 and the rest read 0.
- Inhibit and event-select changes take effect from the cycle after the write.
- No privilege/mcounteren check in this block.

Test Plan:
- Reset, run 10 cycles, instr_ret_i=1 on 4 of them -> read 0xB00=10 (±read cycle alignment, checked exactly by model), 0xB02=4, 0xC02=4, 0xC01=0.
- WRITE 0xB00=0xFFFFFFFF, 0xB80=0x0 -> two cycles later 0xB80 reads 1 and 0xB00 reads 0x00000000; with COUNTER_WIDTH=64, hi=lo=0xFFFFFFFF wraps to 0 after one cycle.
- WRITE 0x323=3, pulse hpm_event_i[2] 5 times and hpm_event_i[0] 7 times -> 0xB03=5; WRITE 0x323=NUM_EVENTS+1 -> no further counts.
- SET 0x320 with 0x5 -> mcycle/minstret frozen while HPM keeps counting. Read 0x320 = 0x5. CLEAR 0x320 with 0x1 -> mcycle resumes the next cycle.
- csr_we to 0xC00 with WRITE 0x1234 -> csr_illegal=1, mcycle unaffected. Same address with csr_we=0 -> csr_illegal=0, csr_hit=1.
- Write 0xB03+NUM_HPM (unimplemented) -> reads 0, no illegal. Assert rst_n=0 mid-count -> all counters 0 immediately (async), counting resumes after release.
